// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, fixed WIDTH-cycle latency.
// Results satisfy dividend == quotient*divisor + remainder; divisor==0 is flagged, not special-cased.
module seq_restoring_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_RUN    | one restoring step per cycle, counter WIDTH-1 down to 0
  // S_FINISH | results just written, done high; start accepted here too
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz_pend;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_r_sh;
  logic [WIDTH:0]   w_t;
  logic             w_fits;
  logic [WIDTH:0]   w_r_nx;
  logic [WIDTH-1:0] w_q_nx;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == '0);

  // Restoring step: trial-subtract the divisor, keep the difference only if non-negative.
  assign w_r_sh = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_t    = w_r_sh - {1'b0, r_d};
  assign w_fits = ~w_t[WIDTH];
  assign w_r_nx = w_fits ? w_t : w_r_sh;
  assign w_q_nx = {r_q[WIDTH-2:0], w_fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nx = S_RUN;
      S_RUN:    if (w_last) w_state_nx = S_FINISH;
      S_FINISH: w_state_nx = start ? S_RUN : S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_dbz_pend  <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_q        <= dividend;
      r_d        <= divisor;
      r_r        <= '0;
      r_cnt      <= CW'(WIDTH - 1);
      r_dbz_pend <= (divisor == '0);
    end else if (r_state == S_RUN) begin
      r_q <= w_q_nx;
      r_r <= w_r_nx;
      if (w_last) begin
        // Publish the final step's values directly so results land on the same edge.
        quotient    <= w_q_nx;
        remainder   <= w_r_nx[WIDTH-1:0];
        div_by_zero <= r_dbz_pend;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule
